// File: rtl/i2s_sample_tx.sv
// rtl/i2s_sample_tx.sv - stereo sample FIFO re-serialized as Philips I2S (BCLK, LRCLK, SDATA)
module i2s_sample_tx #(
    parameter int BCLK_DIV   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [15:0]                   in_left,
    input  logic [15:0]                   in_right,
    input  logic                          in_valid,
    output logic                          i2s_bclk,
    output logic                          i2s_lrclk,
    output logic                          i2s_sdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    logic [DW-1:0] div_q, div_d;
    logic          bclk_q, bclk_d;
    logic [4:0]    slot_q, slot_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic [31:0]   shift_q, shift_d;
    logic [31:0]   last_q, last_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic        wrap, fall, frame_start, empty, full, pop, push;
    logic [4:0]  slot_p2;
    logic [31:0] head;

    always_comb begin
        wrap        = (div_q == DIV_MAX);
        fall        = wrap & bclk_q;
        frame_start = fall & (slot_q == 5'd31);
        empty       = (level_q == '0);
        full        = (level_q == LVL_FULL);
        pop         = frame_start & ~empty;
        // A pop in the same cycle frees a slot, so a full FIFO can still accept.
        push        = in_valid & (~full | pop);
        head        = mem_q[rd_q];
        slot_p2     = slot_q + 5'd2;

        div_d   = wrap ? '0 : div_q + 1'b1;
        bclk_d  = wrap ? ~bclk_q : bclk_q;
        slot_d  = slot_q;
        lrclk_d = lrclk_q;
        sdata_d = sdata_q;
        shift_d = shift_q;
        last_d  = last_q;

        if (fall) begin
            slot_d  = slot_q + 5'd1;
            // Word select leads the data by one bit clock.
            lrclk_d = slot_p2[4];
            if (frame_start) begin
                if (!empty) begin
                    shift_d = head;
                    last_d  = head;
                end else begin
                    shift_d = last_q;
                end
            end else begin
                shift_d = {shift_q[30:0], 1'b0};
            end
            sdata_d = shift_d[31];
        end

        rd_d    = pop  ? rd_q + 1'b1 : rd_q;
        wr_d    = push ? wr_q + 1'b1 : wr_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end

        ovf_d = in_valid & ~push;
        unf_d = frame_start & empty;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q   <= '0;
            bclk_q  <= 1'b0;
            slot_q  <= 5'd31;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
            shift_q <= '0;
            last_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            div_q   <= div_d;
            bclk_q  <= bclk_d;
            slot_q  <= slot_d;
            lrclk_q <= lrclk_d;
            sdata_q <= sdata_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (push) begin
                mem_q[wr_q] <= {in_left, in_right};
            end
        end
    end

    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_i2s_sample_tx.sv
// tb/tb_i2s_sample_tx.sv - scoreboard bench for i2s_sample_tx (BCLK_DIV=2 and BCLK_DIV=1 instances)
module tb_i2s_sample_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] in_left = '0;
    logic [15:0] in_right = '0;
    logic        in_valid = 1'b0;

    logic       bclk, lrclk, sdata, ovf, unf;
    logic [2:0] level;
    logic       bclk1, lrclk1, sdata1, ovf1, unf1;
    logic [2:0] level1;

    int n_cmp = 0;
    int n_err = 0;

    i2s_sample_tx #(.BCLK_DIV(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_left(in_left), .in_right(in_right),
        .in_valid(in_valid), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
        .fifo_level(level), .overflow(ovf), .underflow(unf)
    );

    i2s_sample_tx #(.BCLK_DIV(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_left(in_left), .in_right(in_right),
        .in_valid(in_valid), .i2s_bclk(bclk1), .i2s_lrclk(lrclk1), .i2s_sdata(sdata1),
        .fifo_level(level1), .overflow(ovf1), .underflow(unf1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int pcyc = 0;
    always @(posedge clk) begin
        if (!reset_n) pcyc <= 0;
        else          pcyc <= pcyc + 1;
    end

    logic [31:0] exp_q[$];
    logic [31:0] last_pair = '0;
    logic [31:0] exp_word = '0;
    logic [31:0] word = '0;
    logic        prev_bclk = 1'b0;
    logic        have_frame = 1'b0;
    int rise_cnt = 0, mon_slot = 31, last_rise = -1;
    int frame_cnt = 0, uf_cnt = 0, ovf_cnt = 0, exp_uf = 0;

    always @(negedge clk) begin
        if (!reset_n || pcyc == 0) begin
            rise_cnt   = 0;
            mon_slot   = 31;
            prev_bclk  = 1'b0;
            have_frame = 1'b0;
            last_rise  = -1;
            last_pair  = '0;
            if (!reset_n) exp_q.delete();
        end else begin
            if (unf) uf_cnt++;
            if (ovf) ovf_cnt++;
            if (bclk && !prev_bclk) begin
                mon_slot = (rise_cnt + 31) % 32;
                rise_cnt++;
                chk("lrclk_slot", {31'd0, lrclk}, {31'd0, (mon_slot >= 15 && mon_slot <= 30)});
                if (last_rise >= 0) chk("bclk_period", pcyc - last_rise, 32'd4);
                last_rise = pcyc;
                if (mon_slot == 0) begin
                    if (exp_q.size() > 0) begin
                        exp_word  = exp_q.pop_front();
                        last_pair = exp_word;
                    end else begin
                        exp_word = last_pair;
                        exp_uf++;
                    end
                    word       = '0;
                    have_frame = 1'b1;
                    frame_cnt++;
                end
                word = {word[30:0], sdata};
                if (mon_slot == 31 && have_frame) chk("frame_word", word, exp_word);
            end
            prev_bclk = bclk;
        end
    end

    logic [31:0] word1 = '0;
    logic        prev1 = 1'b0;
    logic        done1 = 1'b0;
    int r1 = 0;

    always @(negedge clk) begin
        if (!reset_n || pcyc == 0) begin
            r1    = 0;
            prev1 = 1'b0;
        end else begin
            if (!done1) chk("bclk1_toggle", {31'd0, bclk1}, {31'd0, ~prev1});
            if (bclk1 && !prev1) begin
                r1++;
                if (r1 >= 2 && !done1) word1 = {word1[30:0], sdata1};
                if (r1 == 33 && !done1) begin
                    chk("div1_word", word1, 32'h8001_7FFE);
                    done1 = 1'b1;
                end
            end
            prev1 = bclk1;
        end
    end

    task automatic push_pair(input logic [15:0] l, input logic [15:0] r, input bit acc);
        in_left  = l;
        in_right = r;
        in_valid = 1'b1;
        if (acc) exp_q.push_back({l, r});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int n);
        int t = 0;
        while (frame_cnt < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_frames", {31'd0, frame_cnt >= n}, 32'd1);
    endtask

    task automatic wait_pcyc(input int c);
        int t = 0;
        while (pcyc != c && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("wait_pcyc", pcyc, c);
    endtask

    task automatic first_frame_level;
        chk("level_after_push", {29'd0, level}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        chk("level_before_frame", {29'd0, level}, 32'd1);
        @(negedge clk);
        chk("level_at_frame_start", {29'd0, level}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'd0, bclk, lrclk, sdata, ovf, unf, 1'b0}, 32'd0);
        chk("reset_level", {29'd0, level}, 32'd0);
        chk("reset_dut1", {23'd0, bclk1, lrclk1, sdata1, level1, ovf1, unf1}, 32'd0);

        reset_n = 1'b1;
        push_pair(16'h8001, 16'h7FFE, 1'b1);
        first_frame_level();

        wait_frames(3);
        chk("underflow_frames_2_3", uf_cnt, 32'd2);
        push_pair(16'h1111, 16'h2222, 1'b1);
        push_pair(16'h3333, 16'h4444, 1'b1);
        push_pair(16'h5555, 16'h6666, 1'b1);
        push_pair(16'h7777, 16'h8888, 1'b1);
        push_pair(16'h9999, 16'hAAAA, 1'b0);
        @(negedge clk);
        chk("level_full", {29'd0, level}, 32'd4);
        chk("overflow_once", ovf_cnt, 32'd1);

        wait_frames(4);
        chk("level_after_pop", {29'd0, level}, 32'd3);
        push_pair(16'hCAFE, 16'hF00D, 1'b1);
        wait_pcyc(515);
        chk("level_full_before_fs", {29'd0, level}, 32'd4);
        push_pair(16'hBEEF, 16'h0123, 1'b1);
        chk("fs_push_level", {29'd0, level}, 32'd4);
        chk("fs_push_no_overflow", {31'd0, ovf}, 32'd0);
        chk("fs_no_underflow", {31'd0, unf}, 32'd0);

        wait_frames(11);
        chk("underflow_count", uf_cnt, exp_uf);
        chk("overflow_total", ovf_cnt, 32'd1);
        chk("fifo_drained", {29'd0, level}, 32'd0);

        begin
            int t = 0;
            while (mon_slot < 20 && t < 500) begin
                @(negedge clk);
                t++;
            end
            chk("reach_right_word", {31'd0, mon_slot >= 20}, 32'd1);
        end
        push_pair(16'h5A5A, 16'hA5A5, 1'b0);
        #3 reset_n = 1'b0;
        #1;
        chk("midreset_pins", {29'd0, bclk, lrclk, sdata}, 32'd0);
        chk("midreset_level", {29'd0, level}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        push_pair(16'h1234, 16'hABCD, 1'b1);
        first_frame_level();

        wait_frames(13);
        chk("final_underflow_count", uf_cnt, exp_uf);
        chk("div1_done", {31'd0, done1}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
